// File: rtl/mult_arbiter_if.sv
// Bus bundle between the filter requesters, the shared multiplier and mult_arbiter.
// The slave side is the arbiter; the master side is the requesters plus the multiplier.
interface mult_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int COEF_SIZE = 25
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]                req;
  logic [NREQ-1:0]                lock;
  logic                           hold;
  logic [NREQ*COEF_SIZE-1:0]      op_a;
  logic [NREQ*COEF_SIZE-1:0]      op_b;
  logic [NREQ-1:0]                grant;
  logic signed [COEF_SIZE-1:0]    mul_a;
  logic signed [COEF_SIZE-1:0]    mul_b;
  logic signed [2*COEF_SIZE-1:0]  mul_p;
  logic                           res_valid;
  logic [IDW-1:0]                 res_id;
  logic signed [2*COEF_SIZE-1:0]  res_p;
  logic                           busy;

  modport master (
    output req, lock, hold, op_a, op_b, mul_p,
    input  grant, mul_a, mul_b, res_valid, res_id, res_p, busy
  );

  modport slave (
    input  req, lock, hold, op_a, op_b, mul_p,
    output grant, mul_a, mul_b, res_valid, res_id, res_p, busy
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NREQ filter channels.
// A {valid, id} tag pipeline follows each issue so the product comes back labelled.
module mult_arbiter #(
  parameter int NREQ      = 4,
  parameter int COEF_SIZE = 25,
  parameter int MULT_LAT  = 1
) (
  input  logic           clk,
  input  logic           reset,
  mult_arbiter_if.slave  bus
);
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = 1 + MULT_LAT;

  logic [IDW-1:0]              ptr_r;
  logic [IDW-1:0]              idx_s;
  logic [IDW-1:0]              gnt_id_s;
  logic [IDW-1:0]              ptr_nxt_s;
  logic                        found_s;
  logic                        hit_s;
  logic                        issue_s;
  logic [NREQ-1:0]             grant_s;
  logic signed [COEF_SIZE-1:0] mul_a_r;
  logic signed [COEF_SIZE-1:0] mul_b_r;
  logic [DEPTH-1:0]            vld_r;
  logic [IDW-1:0]              id_r [DEPTH];

  // First requester at or after ptr_r (wrapping) wins; hold and reset veto any issue.
  always_comb begin
    found_s  = 1'b0;
    gnt_id_s = '0;
    idx_s    = '0;
    hit_s    = 1'b0;
    grant_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s    = IDW'((int'(ptr_r) + k) % NREQ);
      hit_s    = !found_s && bus.req[idx_s];
      gnt_id_s = hit_s ? idx_s : gnt_id_s;
      found_s  = found_s || hit_s;
    end
    if (!reset && !bus.hold && found_s) begin
      grant_s[gnt_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign issue_s = |grant_s;

  // A locked winner keeps the pointer on itself; otherwise the pointer moves past it.
  always_comb begin
    ptr_nxt_s = '0;
    if (bus.lock[gnt_id_s]) begin
      ptr_nxt_s = gnt_id_s;
    end else if (gnt_id_s == IDW'(NREQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gnt_id_s + IDW'(1);
    end
  end

  // Pointer and operand registers; operands are forced to zero when nothing issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r   <= '0;
      mul_a_r <= '0;
      mul_b_r <= '0;
    end else if (issue_s) begin
      ptr_r   <= ptr_nxt_s;
      mul_a_r <= $signed(bus.op_a[gnt_id_s*COEF_SIZE +: COEF_SIZE]);
      mul_b_r <= $signed(bus.op_b[gnt_id_s*COEF_SIZE +: COEF_SIZE]);
    end else begin
      mul_a_r <= '0;
      mul_b_r <= '0;
    end
  end

  // Tag pipeline aligned with the multiplier: stage 0 sits beside the operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_r[i] <= '0;
      end
    end else begin
      vld_r[0] <= issue_s;
      id_r[0]  <= gnt_id_s;
      for (int i = 1; i < DEPTH; i++) begin
        vld_r[i] <= vld_r[i-1];
        id_r[i]  <= id_r[i-1];
      end
    end
  end

  // Outputs read as cleared for the whole reset cycle, not just after the edge.
  assign bus.grant     = grant_s;
  assign bus.mul_a     = reset ? '0 : mul_a_r;
  assign bus.mul_b     = reset ? '0 : mul_b_r;
  assign bus.res_valid = !reset && vld_r[DEPTH-1];
  assign bus.res_id    = reset ? '0 : id_r[DEPTH-1];
  assign bus.res_p     = bus.mul_p;
  assign bus.busy      = !reset && (|vld_r);
endmodule

// File: tb/tb_mult_arbiter.sv
// Randomised bench for mult_arbiter with a history-based reference model; two instances
// (MULT_LAT=1 and MULT_LAT=3) share the same stimulus and each gets its own multiplier model.
module tb_mult_arbiter;
  localparam int NREQ = 4;
  localparam int CS   = 25;
  localparam int MAXC = 4096;

  logic clk;
  logic reset;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] lock;
  logic hold;
  logic [NREQ*CS-1:0] op_a;
  logic [NREQ*CS-1:0] op_b;
  logic signed [2*CS-1:0] p1;
  logic signed [2*CS-1:0] p3a, p3b, p3c;

  int total = 0;
  int bad   = 0;

  mult_arbiter_if #(.NREQ(NREQ), .COEF_SIZE(CS)) if1 ();
  mult_arbiter_if #(.NREQ(NREQ), .COEF_SIZE(CS)) if3 ();

  mult_arbiter #(.NREQ(NREQ), .COEF_SIZE(CS), .MULT_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));
  mult_arbiter #(.NREQ(NREQ), .COEF_SIZE(CS), .MULT_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave));

  assign if1.req = req;   assign if3.req = req;
  assign if1.lock = lock; assign if3.lock = lock;
  assign if1.hold = hold; assign if3.hold = hold;
  assign if1.op_a = op_a; assign if3.op_a = op_a;
  assign if1.op_b = op_b; assign if3.op_b = op_b;
  assign if1.mul_p = p1;
  assign if3.mul_p = p3c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier models: one and three register stages after the operand registers.
  always @(posedge clk) begin
    p1  <= if1.mul_a * if1.mul_b;
    p3a <= if3.mul_a * if3.mul_b;
    p3b <= p3a;
    p3c <= p3b;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-cycle history of issues and resets.
  bit                 rst_h [MAXC];
  bit                 iss   [MAXC];
  int                 iid   [MAXC];
  logic signed [CS-1:0] ia  [MAXC];
  logic signed [CS-1:0] ib  [MAXC];
  int                 cyc  = 0;
  int                 mptr = 0;
  int                 gid;
  logic [NREQ-1:0]    eg;
  logic signed [CS-1:0] ea, eb;

  // An issue at cycle t survives to cycle c unless reset was seen in any cycle t+1..c.
  function automatic bit alive(input int t, input int c);
    if (t < 0) return 1'b0;
    if (!iss[t]) return 1'b0;
    for (int u = t + 1; u <= c; u++) begin
      if (rst_h[u]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_res(input string tag, input int lat, input logic v,
                           input logic [1:0] id, input logic signed [2*CS-1:0] p,
                           input logic b);
    int t;
    bit ev;
    bit ebusy;
    logic signed [2*CS-1:0] ep;
    t  = cyc - 1 - lat;
    ev = alive(t, cyc);
    chk({tag, "_valid"}, longint'(v), longint'(ev));
    ebusy = 1'b0;
    for (int u = cyc - 1 - lat; u <= cyc - 1; u++) begin
      if (alive(u, cyc)) ebusy = 1'b1;
    end
    chk({tag, "_busy"}, longint'(b), longint'(ebusy));
    if (ev) begin
      ep = ia[t] * ib[t];
      chk({tag, "_id"}, longint'(id), longint'(iid[t]));
      chk({tag, "_p"}, longint'(p), longint'(ep));
    end
  endtask

  // Compare process: evaluate the model for this cycle and check both instances.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      rst_h[cyc] = reset;
      gid = -1;
      if (!reset && !hold) begin
        for (int k = 0; k < NREQ; k++) begin
          if (gid < 0 && req[(mptr + k) % NREQ]) gid = (mptr + k) % NREQ;
        end
      end
      eg = '0;
      iss[cyc] = (gid >= 0);
      if (gid >= 0) begin
        eg[gid]  = 1'b1;
        iid[cyc] = gid;
        ia[cyc]  = $signed(op_a[gid*CS +: CS]);
        ib[cyc]  = $signed(op_b[gid*CS +: CS]);
      end
      chk("grant_l1", longint'(if1.grant), longint'(eg));
      chk("grant_l3", longint'(if3.grant), longint'(eg));
      ea = '0;
      eb = '0;
      if (!reset && cyc > 0 && iss[cyc-1]) begin
        ea = ia[cyc-1];
        eb = ib[cyc-1];
      end
      chk("mul_a_l1", longint'(if1.mul_a), longint'(ea));
      chk("mul_b_l1", longint'(if1.mul_b), longint'(eb));
      chk("mul_a_l3", longint'(if3.mul_a), longint'(ea));
      chk("mul_b_l3", longint'(if3.mul_b), longint'(eb));
      check_res("res_l1", 1, if1.res_valid, if1.res_id, if1.res_p, if1.busy);
      check_res("res_l3", 3, if3.res_valid, if3.res_id, if3.res_p, if3.busy);
      chk("res_p_pass_l1", longint'(if1.res_p), longint'(p1));
      if (reset) mptr = 0;
      else if (gid >= 0) mptr = lock[gid] ? gid : (gid + 1) % NREQ;
      cyc++;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fair_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int         fair_id [5] = '{0, 1, 2, 3, 0};
  logic [3:0] lock_g [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};

  initial begin
    reset = 1'b1; req = 4'b1111; lock = '0; hold = 1'b0; op_a = '0; op_b = '0;
    nxt();
    @(negedge clk);
    chk("rst_grant", longint'(if1.grant), 64'd0);
    chk("rst_valid", longint'(if1.res_valid), 64'd0);
    chk("rst_busy", longint'(if3.busy), 64'd0);

    // Single issue: 3 x -2
    nxt();
    reset = 1'b0; req = 4'b0001;
    op_a[0 +: CS] = 25'sd3; op_b[0 +: CS] = -25'sd2;
    @(negedge clk);
    chk("single_grant", longint'(if1.grant), 64'd1);
    nxt();
    req = 4'b0000;
    @(negedge clk);
    chk("single_mul_a", longint'(if1.mul_a), 64'sd3);
    chk("single_mul_b", longint'(if1.mul_b), -64'sd2);
    nxt();
    @(negedge clk);
    chk("single_valid", longint'(if1.res_valid), 64'd1);
    chk("single_id", longint'(if1.res_id), 64'd0);
    chk("single_p", longint'(if1.res_p), -64'sd6);

    // Fairness with all requesting
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0; req = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) nxt();
      @(negedge clk);
      if (k < 5) chk("fair_grant", longint'(if1.grant), longint'(fair_g[k]));
      if (k >= 2) begin
        chk("fair_valid", longint'(if1.res_valid), 64'd1);
        chk("fair_id", longint'(if1.res_id), longint'(fair_id[k-2]));
      end
    end

    // Lock on requester 0 for three cycles
    nxt(); reset = 1'b1; req = 4'b0000;
    nxt(); reset = 1'b0; req = 4'b0011; lock = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) nxt();
      if (k == 3) lock = 4'b0000;
      @(negedge clk);
      chk("lock_grant", longint'(if1.grant), longint'(lock_g[k]));
    end

    // Hold for three cycles after one issue
    nxt(); reset = 1'b1; req = 4'b0000;
    nxt(); reset = 1'b0; req = 4'b0100;
    @(negedge clk);
    chk("hold_pre_grant", longint'(if1.grant), 64'd4);
    for (int k = 0; k < 3; k++) begin
      nxt(); hold = 1'b1;
      @(negedge clk);
      chk("hold_grant", longint'(if1.grant), 64'd0);
      if (k == 1) begin
        chk("hold_drain_valid", longint'(if1.res_valid), 64'd1);
        chk("hold_drain_id", longint'(if1.res_id), 64'd2);
      end
    end
    nxt(); hold = 1'b0;
    @(negedge clk);
    chk("hold_resume", longint'(if1.grant), 64'd4);

    // Reset while a product is in flight
    nxt(); reset = 1'b1; req = 4'b0000;
    nxt(); reset = 1'b0; req = 4'b0001;
    @(negedge clk);
    chk("rmid_grant", longint'(if1.grant), 64'd1);
    nxt(); reset = 1'b1; req = 4'b0000;
    @(negedge clk);
    chk("rmid_busy_in_rst", longint'(if1.busy), 64'd0);
    nxt(); reset = 1'b0; req = 4'b1000;
    @(negedge clk);
    chk("rmid_valid", longint'(if1.res_valid), 64'd0);
    chk("rmid_busy", longint'(if1.busy), 64'd0);
    chk("rmid_grant2", longint'(if1.grant), 64'd8);
    nxt(); req = 4'b0000;
    @(negedge clk);
    chk("rmid_no_stale", longint'(if1.res_valid), 64'd0);
    nxt();
    @(negedge clk);
    chk("rmid_new_valid", longint'(if1.res_valid), 64'd1);
    chk("rmid_new_id", longint'(if1.res_id), 64'd3);

    // Three-stage multiplier with the most negative operands
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0; req = 4'b0010;
    op_a[CS +: CS] = 25'h1000000; op_b[CS +: CS] = 25'h1000000;
    @(negedge clk);
    chk("lat3_grant", longint'(if3.grant), 64'd2);
    nxt(); req = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) nxt();
      @(negedge clk);
      chk("lat3_early", longint'(if3.res_valid), 64'd0);
    end
    nxt();
    @(negedge clk);
    chk("lat3_valid", longint'(if3.res_valid), 64'd1);
    chk("lat3_id", longint'(if3.res_id), 64'd1);
    chk("lat3_p", longint'(if3.res_p), 64'sd281474976710656);

    // Random traffic, checked cycle by cycle by the model
    for (int n = 0; n < 3000; n++) begin
      nxt();
      reset = ($urandom_range(0, 63) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      req   = 4'($urandom);
      lock  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      for (int i = 0; i < NREQ; i++) begin
        op_a[i*CS +: CS] = 25'($urandom);
        op_b[i*CS +: CS] = 25'($urandom);
      end
    end
    nxt();
    reset = 1'b0; req = '0; hold = 1'b0; lock = '0;
    repeat (6) nxt();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NREQ, 4, number of requesters (filter channels) sharing one multiplier.
- COEF_SIZE, 25, signed operand width.
- MULT_LAT, 1, multiplier pipeline latency in cycles (mult_gen_0 = 1).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- reset, in, 1, synchronous active-high reset.
- req, in, NREQ, per-requester multiply request, level.
- lock, in, NREQ, requester keeps the grant next cycle while high.
- hold, in, 1, blocks new grants; in-flight products drain.
- op_a, in, NREQ*COEF_SIZE, packed signed operand A; requester i uses slice i.
- op_b, in, NREQ*COEF_SIZE, packed signed operand B; requester i uses slice i.
- grant, out, NREQ, one-hot issue strobe, combinational, same cycle as the accepted request.
- mul_a, out, COEF_SIZE, registered operand A to the multiplier.
- mul_b, out, COEF_SIZE, registered operand B to the multiplier.
- mul_p, in, 2*COEF_SIZE, signed multiplier product.
- res_valid, out, 1, product valid strobe.
- res_id, out, clog2(NREQ), index of the requester owning res_p.
- res_p, out, 2*COEF_SIZE, signed product, passed through from mul_p.
- busy, out, 1, high while any product is in flight.

Function
REQ-003 Single clock domain; all state SHALL update on posedge clk.
REQ-004 Arbitration SHALL be round-robin from pointer ptr: grant the first i with req[i]=1, searching ptr, ptr+1, ..., NREQ-1, 0, ... (mod NREQ).
REQ-005 grant SHALL be all-zero when hold=1, when reset=1, or when req=0.
REQ-006 After a grant to i: ptr SHALL become i if lock[i]=1, else (i+1) mod NREQ; with no grant, ptr SHALL be unchanged.
REQ-007 A locked requester that drops req SHALL lose its priority; arbitration resumes from ptr=i (the lock has no effect without req).
REQ-008 Operand issue: on a grant to i in cycle t, mul_a/mul_b SHALL equal op_a[i]/op_b[i] during cycle t+1; in non-issue cycles they SHALL be 0.
REQ-009 A tag pipeline {valid, id} of depth 1+MULT_LAT SHALL track each issue; res_valid=1 and res_id=i SHALL appear in cycle t+1+MULT_LAT.
REQ-010 res_p SHALL equal mul_p in every cycle; it is meaningful only when res_valid=1.
REQ-011 Throughput SHALL be one issue per cycle; back-to-back grants SHALL produce back-to-back res_valid in the same order.
REQ-012 busy SHALL be the OR of all tag-pipeline valid bits.
REQ-013 hold asserted in cycle t SHALL suppress issue in t only; products already issued SHALL still complete.
REQ-014 Operand and product widths SHALL be exact two's complement; the block performs no scaling or truncation (the requester applies >>>(COEF_SIZE-2)).

Reset
REQ-015 While reset=1: ptr=0, tag pipeline cleared, mul_a=mul_b=0, grant=0, res_valid=0, res_id=0, busy=0.
REQ-016 Reset during an operation SHALL discard all in-flight products; res_valid SHALL be 0 in every cycle after reset until a new issue has traversed the pipeline.

Verification
REQ-017 Single issue: req=0001, op_a0=3, op_b0=-2 in cycle t -> grant=0001 at t; mul_a=3 and mul_b=-2 at t+1; res_valid=1, res_id=0, res_p=-6 at t+2.
REQ-018 Fairness: req=1111 held, lock=0 -> grant sequence 0001, 0010, 0100, 1000, 0001; res_id sequence 0,1,2,3,0; res_valid continuous.
REQ-019 Lock: req=0011, lock[0]=1 for 3 cycles then 0 -> grant 0001 for 4 cycles (3 locked plus the cycle lock drops), then 0010.
REQ-020 Hold: req=0100, hold=1 for cycles t..t+2 -> grant=0 for 3 cycles, first grant=0100 at t+3; a product issued at t-1 still delivers res_valid at t+1.
REQ-021 Reset mid-flight: issue at t, reset=1 at t+1 -> res_valid=0 at t+2, busy=0, ptr=0; the next req=1000 is granted without a stale result.
REQ-022 Latency sweep: MULT_LAT=3 with a 3-stage multiplier model -> res_valid at t+4; operands -16777216 x -16777216 give res_p=281474976710656.
